// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: key codes consumed by the
// control FSM and the keypad scanner's state encoding.
package calc_pkg;

    localparam logic [3:0] KEY_PLUS    = 4'b1010;
    localparam logic [3:0] KEY_MINUS   = 4'b1011;
    localparam logic [3:0] KEY_EQUAL   = 4'b1100;
    localparam logic [3:0] KEY_SPARE_A = 4'b1101;
    localparam logic [3:0] KEY_SPARE_B = 4'b1110;
    localparam logic [3:0] KEY_RESET   = 4'b1111;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic       tipo;
        logic [3:0] code;
    } key_t;

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        col_drive = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
module row_sync (
    input  logic       clk,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, row debounce and key encoding,
// delivering each press once as a key_valid strobe with tipo/number.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       tipo,
    output logic [3:0] number,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t      state;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       col_idx;
    logic [1:0]       lat_row;
    logic [3:0]       lat_pat;
    logic [3:0]       row_s;
    logic [1:0]       low_row;

    row_sync u_row_sync (
        .clk (clk),
        .d   (row),
        .q   (row_s)
    );

    function automatic key_t encode_key(input logic [1:0] r, input logic [1:0] c);
        key_t k;
        k = {1'b1, KEY_RESET};
        case ({r, c})
            4'h0: k = {1'b0, 4'd1};
            4'h1: k = {1'b0, 4'd2};
            4'h2: k = {1'b0, 4'd3};
            4'h3: k = {1'b1, KEY_PLUS};
            4'h4: k = {1'b0, 4'd4};
            4'h5: k = {1'b0, 4'd5};
            4'h6: k = {1'b0, 4'd6};
            4'h7: k = {1'b1, KEY_MINUS};
            4'h8: k = {1'b0, 4'd7};
            4'h9: k = {1'b0, 4'd8};
            4'hA: k = {1'b0, 4'd9};
            4'hB: k = {1'b1, KEY_EQUAL};
            4'hC: k = {1'b1, KEY_SPARE_A};
            4'hD: k = {1'b0, 4'd0};
            4'hE: k = {1'b1, KEY_SPARE_B};
            default: k = {1'b1, KEY_RESET};
        endcase
        return k;
    endfunction

    // Lowest-index low row wins when several rows are pulled down.
    always_comb begin
        low_row = 2'd3;
        casez (row_s)
            4'b???0: low_row = 2'd0;
            4'b??01: low_row = 2'd1;
            4'b?011: low_row = 2'd2;
            default: low_row = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            div       <= '0;
            cnt       <= '0;
            col_idx   <= '0;
            col       <= 4'b1110;
            lat_row   <= '0;
            lat_pat   <= '1;
            tipo      <= 1'b0;
            number    <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (row_s != '1) begin
                            lat_pat <= row_s;
                            lat_row <= low_row;
                            cnt     <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col     <= col_drive(col_idx + 2'd1);
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_s == lat_pat) begin
                        if (cnt == CNT_LAST) begin
                            {tipo, number} <= encode_key(lat_row, col_idx);
                            key_valid      <= 1'b1;
                            key_held       <= 1'b1;
                            cnt            <= '0;
                            state          <= PRESSED;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        div     <= '0;
                        col_idx <= col_idx + 2'd1;
                        col     <= col_drive(col_idx + 2'd1);
                        state   <= SCAN;
                    end
                end
                PRESSED: begin
                    // Release needs a full run of all-high samples; any low row restarts it.
                    if (row_s == '1) begin
                        if (cnt == CNT_LAST) begin
                            key_held <= 1'b0;
                            cnt      <= '0;
                            div      <= '0;
                            col_idx  <= col_idx + 2'd1;
                            col      <= col_drive(col_idx + 2'd1);
                            state    <= SCAN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a switch-matrix keypad model drives
// the rows from the column outputs; expectations come from the key table and timing rules.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DEB = 3;
    localparam int PRESS_LAT   = SD + DEB;
    localparam int RELEASE_LAT = 2 + DEB;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic       tipo;
    logic [3:0] number;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = '0;
    logic        bounce = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] exp_map [16] = '{
        5'h01, 5'h02, 5'h03, 5'h1A,
        5'h04, 5'h05, 5'h06, 5'h1B,
        5'h07, 5'h08, 5'h09, 5'h1C,
        5'h1D, 5'h00, 5'h1E, 5'h1F
    };

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .tipo      (tipo),
        .number    (number),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
        if (bounce) row = 4'hF;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus/measurement only: presses the keys in mask and watches column c.
    task automatic do_press(input logic [15:0] mask, input int c, input int hold,
                            output int lat, output int pulses, output logic [4:0] code,
                            output bit held_ok, output bit stable, output int rel);
        int n;
        pulses = 0; held_ok = 1'b1; stable = 1'b1; code = '0; lat = -1; rel = -1;
        n = 0;
        while (col[c] == 1'b0 && n < 40) begin tick(); pulses += key_valid; n++; end
        keys = keys | mask;
        n = 0;
        while (col[c] == 1'b1 && n < 40) begin tick(); pulses += key_valid; n++; end
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            pulses += key_valid;
            if (key_valid) break;
        end
        if (key_valid) lat = n;
        code = {tipo, number};
        held_ok = key_held;
        for (int i = 0; i < hold; i++) begin
            tick();
            pulses += key_valid;
            if (!key_held) held_ok = 1'b0;
            if ({tipo, number} != code) stable = 1'b0;
        end
        keys = keys & ~mask;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            pulses += key_valid;
            if (!key_held) break;
        end
        if (!key_held) rel = n;
        if ({tipo, number} != code) stable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        keys = '0;
        repeat (3) tick();
        n_checks++;
        if ({col, tipo, number, key_valid, key_held} !== {4'b1110, 1'b0, 4'b0000, 1'b0, 1'b0})
            $display("FAIL reset_state: got col=%b tipo=%b number=%b valid=%b held=%b, want 1110 0 0000 0 0",
                     col, tipo, number, key_valid, key_held);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col;
        int pulses = 0;
        for (int n = 1; n <= 32; n++) begin
            tick();
            pulses += key_valid;
            exp_col = ~(4'b0001 << ((n / SD) % 4));
            n_checks++;
            if (col !== exp_col) $display("FAIL idle_col[%0d]: got %b want %b", n, col, exp_col);
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 0 || number !== 4'd0)
            $display("FAIL idle_no_key: pulses=%0d number=%b, want 0 and 0000", pulses, number);
        else n_pass++;
    endtask

    task automatic test_clean_press();
        int lat, pulses, rel; logic [4:0] code; bit held_ok, stable;
        do_press(16'h1 << (2*4+1), 1, 10, lat, pulses, code, held_ok, stable, rel);
        n_checks++;
        if (lat !== PRESS_LAT) $display("FAIL press_latency: got %0d want %0d", lat, PRESS_LAT);
        else n_pass++;
        n_checks++;
        if (code !== 5'h08 || pulses !== 1 || !held_ok || !stable)
            $display("FAIL key8: code=%h pulses=%0d held=%b stable=%b, want 08 1 1 1", code, pulses, held_ok, stable);
        else n_pass++;
        n_checks++;
        if (rel !== RELEASE_LAT) $display("FAIL release_latency: got %0d want %0d", rel, RELEASE_LAT);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int n, pulses, lat, rel; logic [4:0] code; bit held_ok, stable;
        pulses = 0;
        n = 0;
        while (col[3] == 1'b0 && n < 40) begin tick(); n++; end
        keys = 16'h1 << (1*4+3);
        n = 0;
        while (col[3] == 1'b1 && n < 40) begin tick(); pulses += key_valid; n++; end
        repeat (3) begin tick(); pulses += key_valid; end
        bounce = 1'b1;
        repeat (2) begin tick(); pulses += key_valid; end
        bounce = 1'b0;
        repeat (3) begin tick(); pulses += key_valid; end
        n_checks++;
        if (col === 4'b0111 || key_held !== 1'b0)
            $display("FAIL bounce_rescan: col=%b held=%b, want column moved on and held=0", col, key_held);
        else n_pass++;
        keys = '0;
        repeat (12) begin tick(); pulses += key_valid; end
        n_checks++;
        if (pulses !== 0) $display("FAIL bounce_no_pulse: got %0d pulses want 0", pulses);
        else n_pass++;
        do_press(16'h1 << (1*4+3), 3, 6, lat, pulses, code, held_ok, stable, rel);
        n_checks++;
        if (code !== 5'h1B || pulses !== 1 || lat !== PRESS_LAT)
            $display("FAIL minus_repress: code=%h pulses=%0d lat=%0d, want 1b 1 %0d", code, pulses, lat, PRESS_LAT);
        else n_pass++;
    endtask

    task automatic test_long_hold();
        int lat, pulses, rel; logic [4:0] code; bit held_ok, stable;
        do_press(16'h1 << (3*4+3), 3, 50, lat, pulses, code, held_ok, stable, rel);
        n_checks++;
        if (code !== 5'h1F || pulses !== 1 || !held_ok || !stable || rel !== RELEASE_LAT)
            $display("FAIL long_hold: code=%h pulses=%0d held=%b stable=%b rel=%0d, want 1f 1 1 1 %0d",
                     code, pulses, held_ok, stable, rel, RELEASE_LAT);
        else n_pass++;
    endtask

    task automatic test_reset_mid_debounce();
        int n, lat, pulses, rel, early; logic [4:0] code; bit held_ok, stable;
        early = 0;
        n = 0;
        while (col[1] == 1'b0 && n < 40) begin tick(); n++; end
        keys = 16'h1 << (1*4+1);
        n = 0;
        while (col[1] == 1'b1 && n < 40) begin tick(); early += key_valid; n++; end
        repeat (SD + 1) begin tick(); early += key_valid; end
        reset = 1'b1;
        tick();
        early += key_valid;
        n_checks++;
        if ({col, tipo, number, key_valid, key_held} !== {4'b1110, 1'b0, 4'b0000, 1'b0, 1'b0} || early !== 0)
            $display("FAIL reset_mid: col=%b tipo=%b number=%b valid=%b held=%b pulses=%0d, want 1110 0 0000 0 0 0",
                     col, tipo, number, key_valid, key_held, early);
        else n_pass++;
        reset = 1'b0;
        do_press(16'h1 << (1*4+1), 1, 5, lat, pulses, code, held_ok, stable, rel);
        n_checks++;
        if (code !== 5'h05 || pulses !== 1 || lat !== PRESS_LAT || !held_ok)
            $display("FAIL reset_reacquire: code=%h pulses=%0d lat=%0d held=%b, want 05 1 %0d 1",
                     code, pulses, lat, held_ok, PRESS_LAT);
        else n_pass++;
    endtask

    task automatic test_two_rows();
        int lat, pulses, rel; logic [4:0] code; bit held_ok, stable;
        do_press((16'h1 << (0*4+0)) | (16'h1 << (2*4+0)), 0, 8, lat, pulses, code, held_ok, stable, rel);
        n_checks++;
        if (code !== 5'h01 || pulses !== 1 || lat !== PRESS_LAT || rel !== RELEASE_LAT)
            $display("FAIL two_rows: code=%h pulses=%0d lat=%0d rel=%0d, want 01 1 %0d %0d",
                     code, pulses, lat, rel, PRESS_LAT, RELEASE_LAT);
        else n_pass++;
    endtask

    task automatic test_random_keys();
        int lat, pulses, rel, r, c, k; logic [4:0] code; bit held_ok, stable;
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            k = r * 4 + c;
            repeat ($urandom_range(0, 9)) tick();
            do_press(16'h1 << k, c, int'($urandom_range(2, 30)), lat, pulses, code, held_ok, stable, rel);
            n_checks++;
            if (code !== exp_map[k] || pulses !== 1 || !held_ok || !stable)
                $display("FAIL rand_key[%0d] r%0dc%0d: code=%h pulses=%0d held=%b stable=%b, want %h 1 1 1",
                         i, r, c, code, pulses, held_ok, stable, exp_map[k]);
            else n_pass++;
            n_checks++;
            if (lat !== PRESS_LAT || rel !== RELEASE_LAT)
                $display("FAIL rand_timing[%0d]: lat=%0d rel=%0d, want %0d %0d",
                         i, lat, rel, PRESS_LAT, RELEASE_LAT);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_reset_mid_debounce();
        test_two_rows();
        test_random_keys();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
